xilinx_dram_mport: RTL and testbench

//  Parametrised multi-read-port distributed (LUT) RAM for 7-series fabric.

---
 rtl/xilinx_dram_pkg.sv | 27 ++
 rtl/xilinx_dram_col.sv | 38 +++
 rtl/xilinx_dram_mport.sv | 109 ++++++++++
 tb/tb_xilinx_dram_mport.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/xilinx_dram_pkg.sv
// Shared types and helpers for the multi-read-port distributed RAM.
// Legal depths, address-width helper, primitive selection and clear-FSM state type.
package xilinx_dram_pkg;

  localparam int DEPTH_32  = 32;
  localparam int DEPTH_64  = 64;
  localparam int DEPTH_128 = 128;
  localparam int DEPTH_256 = 256;

  typedef enum logic [1:0] {P32, P64, P128, P256} prim_e;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic prim_e prim_of(input int depth);
    case (depth)
      DEPTH_32:  return P32;
      DEPTH_64:  return P64;
      DEPTH_128: return P128;
      default:   return P256;
    endcase
  endfunction

endpackage

// File: rtl/xilinx_dram_col.sv
// One 1-bit, DEPTH-deep LUT-RAM column: one synchronous write port, one async read port.
// 256-deep columns are built from two 128-deep halves with a final read mux on the address MSB.
module xilinx_dram_col
  import xilinx_dram_pkg::*;
#(
  parameter int               DEPTH = 64,
  parameter logic [DEPTH-1:0] INIT  = '0,
  localparam int              AW    = aw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic          wd,
  input  logic [AW-1:0] ra,
  output logic          rd
);

  if (prim_of(DEPTH) == P256) begin : g_p256
    logic [127:0] lo = INIT[127:0];
    logic [127:0] hi = INIT[255:128];

    always_ff @(posedge clk) begin
      if (we && !wa[7]) lo[wa[6:0]] <= wd;
      if (we &&  wa[7]) hi[wa[6:0]] <= wd;
    end

    assign rd = ra[7] ? hi[ra[6:0]] : lo[ra[6:0]];
  end else begin : g_single
    logic [DEPTH-1:0] bits = INIT;

    always_ff @(posedge clk) begin
      if (we) bits[wa] <= wd;
    end

    assign rd = bits[ra];
  end

endmodule

// File: rtl/xilinx_dram_mport.sv
// WIDTH x DEPTH distributed RAM with NRD async read ports and a post-reset zero-fill sequencer.
// Define XILINX_DRAM_OREG_EN to register every read port (read-first, zeroed while BUSY).
module xilinx_dram_mport
  import xilinx_dram_pkg::*;
#(
  parameter int                     WIDTH = 8,
  parameter int                     DEPTH = 64,
  parameter int                     NRD   = 2,
  parameter logic [WIDTH*DEPTH-1:0] INIT  = '0,
  localparam int                    AW    = aw_of(DEPTH)
) (
  input  logic                 WCLK,
  input  logic                 RST,
  input  logic                 WE,
  input  logic [AW-1:0]        WA,
  input  logic [WIDTH-1:0]     WD,
  input  logic [NRD*AW-1:0]    RA,
  output logic [NRD*WIDTH-1:0] RD,
  output logic                 BUSY,
  output clr_state_e           dbg_state
);

  // Bit b of every word forms the INIT image of column b.
  function automatic logic [DEPTH-1:0] col_init(input int b);
    logic [DEPTH-1:0] r;
    for (int w = 0; w < DEPTH; w++) r[w] = INIT[w*WIDTH+b];
    return r;
  endfunction

  clr_state_e       state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [NRD*WIDTH-1:0] rd_c;

  always_ff @(posedge WCLK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The counter stops at DEPTH-1 rather than wrapping.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == AW'(DEPTH-1)) state_d = IDLE;
        else                           clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Write mux: sequencer owns the array while clearing; user writes are dropped then.
  always_comb begin
    BUSY   = (state_q == CLEAR);
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!RST) begin
      if (state_q == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt_q;
      end else begin
        mem_we = WE;
        mem_wa = WA;
        mem_wd = WD;
      end
    end
  end

  assign dbg_state = state_q;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      xilinx_dram_col #(
        .DEPTH (DEPTH),
        .INIT  (col_init(b))
      ) u_col (
        .clk (WCLK),
        .we  (mem_we),
        .wa  (mem_wa),
        .wd  (mem_wd[b]),
        .ra  (RA[k*AW +: AW]),
        .rd  (rd_c[k*WIDTH + b])
      );
    end
  end

`ifdef XILINX_DRAM_OREG_EN
  logic [NRD*WIDTH-1:0] rd_q;

  always_ff @(posedge WCLK) begin
    if (RST || BUSY) rd_q <= '0;
    else             rd_q <= rd_c;
  end

  assign RD = rd_q;
`else
  assign RD = rd_c;
`endif

endmodule

// File: tb/tb_xilinx_dram_mport.sv
// Directed self-checking bench: a 64x8 two-port instance and a 256x8 four-port instance.
module tb_xilinx_dram_mport;
  import xilinx_dram_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, busy;
  logic [5:0]  wa;
  logic [7:0]  wd;
  logic [11:0] ra;
  logic [15:0] rd;
  clr_state_e  dbg;

  logic        rst_b, we_b, busy_b;
  logic [7:0]  wa_b, wd_b;
  logic [31:0] ra_b, rd_b;
  clr_state_e  dbg_b;

  xilinx_dram_mport #(.WIDTH(8), .DEPTH(64), .NRD(2)) dut (
    .WCLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
    .RA(ra), .RD(rd), .BUSY(busy), .dbg_state(dbg)
  );

  xilinx_dram_mport #(.WIDTH(8), .DEPTH(256), .NRD(4)) dut256 (
    .WCLK(clk), .RST(rst_b), .WE(we_b), .WA(wa_b), .WD(wd_b),
    .RA(ra_b), .RD(rd_b), .BUSY(busy_b), .dbg_state(dbg_b)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let read data become visible after RA changes.
  task automatic sample();
`ifdef XILINX_DRAM_OREG_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic write_a(input logic [5:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] a, input logic [7:0] d);
    we_b = 1'b1; wa_b = a; wd_b = d;
    tick();
    we_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    rst_b = 1'b1; we_b = 1'b0; wa_b = '0; wd_b = '0; ra_b = '0;
    tick();
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_state", 32'(dbg), 32'(CLEAR));
    check("reset_busy256", 32'(busy_b), 32'd1);
    rst = 1'b0; rst_b = 1'b0;

    // Clear takes exactly 64 edges
    for (int i = 0; i < 64; i++) begin
      check("clear_busy", 32'(busy), 32'd1);
      tick();
    end
    check("clear_done_busy", 32'(busy), 32'd0);
    check("clear_done_state", 32'(dbg), 32'(IDLE));
    for (int w = 0; w < 64; w++) begin
      ra = {6'(63 - w), 6'(w)};
      sample();
      check("clear_rd0", 32'(rd[7:0]), 32'd0);
      check("clear_rd1", 32'(rd[15:8]), 32'd0);
    end

    // Two writes, two ports read different words
    write_a(6'd3, 8'hA5);
    write_a(6'd4, 8'h5A);
    ra = {6'd4, 6'd3};
    sample();
    check("dual_rd0", 32'(rd[7:0]), 32'hA5);
    check("dual_rd1", 32'(rd[15:8]), 32'h5A);

    // Same-cycle write and read of word 7
    we = 1'b1; wa = 6'd7; wd = 8'h11; ra = {6'd7, 6'd7};
`ifdef XILINX_DRAM_OREG_EN
    tick();
    we = 1'b0;
    check("collide_before", 32'(rd[7:0]), 32'h00);
    tick();
    check("collide_after", 32'(rd[7:0]), 32'h11);
    check("collide_after1", 32'(rd[15:8]), 32'h11);
`else
    #1;
    check("collide_before", 32'(rd[7:0]), 32'h00);
    tick();
    we = 1'b0;
    check("collide_after", 32'(rd[7:0]), 32'h11);
    check("collide_after1", 32'(rd[15:8]), 32'h11);
`endif

    // Reset mid-clear restarts; user write held through the clear is dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("midclear_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    we = 1'b1; wa = 6'd0; wd = 8'hFF;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check("restart_busy", 32'(busy), 32'd1);
      tick();
    end
    we = 1'b0;
    check("restart_done", 32'(busy), 32'd0);
    ra = {6'd3, 6'd0};
    sample();
    check("dropped_w0", 32'(rd[7:0]), 32'd0);
    check("recleared_w3", 32'(rd[15:8]), 32'd0);
    ra = {6'd7, 6'd4};
    sample();
    check("recleared_w4", 32'(rd[7:0]), 32'd0);
    check("recleared_w7", 32'(rd[15:8]), 32'd0);

    // 256-deep, four ports
    for (int i = 0; i < 400 && busy_b; i++) tick();
    check("clear256_done", 32'(busy_b), 32'd0);
    write_b(8'd200, 8'h3C);
    ra_b = {4{8'd200}};
    sample();
    check("p256_rd0", 32'(rd_b[7:0]), 32'h3C);
    check("p256_rd1", 32'(rd_b[15:8]), 32'h3C);
    check("p256_rd2", 32'(rd_b[23:16]), 32'h3C);
    check("p256_rd3", 32'(rd_b[31:24]), 32'h3C);
    ra_b = {8'd199, 8'd72, 8'd200, 8'd0};
    sample();
    check("p256_w0", 32'(rd_b[7:0]), 32'h00);
    check("p256_w200", 32'(rd_b[15:8]), 32'h3C);
    check("p256_alias72", 32'(rd_b[23:16]), 32'h00);
    check("p256_w199", 32'(rd_b[31:24]), 32'h00);
    write_b(8'd72, 8'h77);
    ra_b = {8'd200, 8'd72, 8'd200, 8'd72};
    sample();
    check("p256_lo72", 32'(rd_b[7:0]), 32'h77);
    check("p256_hi200", 32'(rd_b[15:8]), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
